// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and
// per-stage control vectors ordered {pc, ifid, idex, exmem, memwb}.
package pipe_pkg;

   localparam int ADDR_W_DEF = 5;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } hz_state_t;

   typedef struct packed {
      logic pc;
      logic ifid;
      logic idex;
      logic exmem;
      logic memwb;
   } stage_en_t;

   // pc has no bubble path; it simply holds or loads
   typedef struct packed {
      logic ifid;
      logic idex;
      logic exmem;
      logic memwb;
   } stage_flush_t;

   localparam stage_en_t    EN_ALL   = stage_en_t'(5'b11111);
   localparam stage_en_t    EN_NONE  = stage_en_t'(5'b00000);
   localparam stage_flush_t FL_NONE  = stage_flush_t'(4'b0000);

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: flags when the instruction in ID reads a register that
// a load currently in EX will write. x0 is never a real dependency.
module load_use_detect #(
   parameter int ADDR_W = 5
) (
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   input  logic              uses_rs1,
   input  logic              uses_rs2,
   input  logic              ex_mem_re,
   input  logic [ADDR_W-1:0] ex_rd_addr,
   output logic              hazard
);

   logic rs1_hit;
   logic rs2_hit;

   // Pure compare, no state
   always_comb begin
      rs1_hit = uses_rs1 && (rs1_addr == ex_rd_addr);
      rs2_hit = uses_rs2 && (rs2_addr == ex_rd_addr);
      hazard  = ex_mem_re && (ex_rd_addr != '0) && (rs1_hit || rs2_hit);
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard/sequencing controller for the 5-stage pipeline.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   RUN      | normal flow; branch flush and load-use bubble handled here
//   MEM_WAIT | data memory busy; pipeline frozen, MEM/WB gets bubbles
//   HALT     | memory timed out; everything frozen until reset
module pipeline_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] id_rs1_addr,
   input  logic [ADDR_W-1:0] id_rs2_addr,
   input  logic              id_uses_rs1,
   input  logic              id_uses_rs2,
   input  logic              idex_mem_re,
   input  logic [ADDR_W-1:0] idex_addr_rd,
   input  logic              exmem_branch_taken,
   input  logic              exmem_mem_re,
   input  logic              exmem_mem_we,
   input  logic              dmem_ready,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              idex_en,
   output logic              exmem_en,
   output logic              memwb_en,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              exmem_flush,
   output logic              memwb_flush,
   output logic              halted,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_count
);

   localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   hz_state_t         state;
   hz_state_t         state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_nxt;
   stage_en_t         en;
   stage_flush_t      fl;
   logic              stall_inc;
   logic              flush_inc;
   logic              load_use;
   logic              mem_access;

   assign mem_access = exmem_mem_re | exmem_mem_we;

   load_use_detect #(.ADDR_W(ADDR_W)) u_load_use (
      .rs1_addr   (id_rs1_addr),
      .rs2_addr   (id_rs2_addr),
      .uses_rs1   (id_uses_rs1),
      .uses_rs2   (id_uses_rs2),
      .ex_mem_re  (idex_mem_re),
      .ex_rd_addr (idex_addr_rd),
      .hazard     (load_use)
   );

   // Next state and stage controls; branch outranks load-use, memory stall outranks both
   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      en        = EN_ALL;
      fl        = FL_NONE;
      flush_inc = 1'b0;
      case (state)
         RUN, MEM_WAIT: begin
            if (mem_access && !dmem_ready && state == RUN) begin
               en        = stage_en_t'(5'b00001);
               fl.memwb  = 1'b1;
               state_nxt = MEM_WAIT;
               wait_nxt  = WAIT_W'(1);
            end else if (state == MEM_WAIT && !dmem_ready) begin
               en        = stage_en_t'(5'b00001);
               fl.memwb  = 1'b1;
               wait_nxt  = wait_cnt + WAIT_W'(1);
               if (wait_cnt == WAIT_LAST)
                  state_nxt = HALT;
            end else begin
               // RUN without a pending miss, or the MEM_WAIT release cycle
               state_nxt = RUN;
               wait_nxt  = '0;
               if (exmem_branch_taken) begin
                  fl.ifid   = 1'b1;
                  fl.idex   = 1'b1;
                  fl.exmem  = 1'b1;
                  flush_inc = 1'b1;
               end else if (load_use) begin
                  en.pc    = 1'b0;
                  en.ifid  = 1'b0;
                  fl.idex  = 1'b1;
               end
            end
         end
         default: begin
            en = EN_NONE;
         end
      endcase
      if (reset) begin
         en        = EN_NONE;
         fl        = FL_NONE;
         flush_inc = 1'b0;
      end
      stall_inc = !reset && (state != HALT) && !en.pc;
      if (state == HALT)
         flush_inc = 1'b0;
   end

   // FSM, wait timer and perf counters
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= RUN;
         wait_cnt     <= '0;
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         if (stall_inc)
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (flush_inc)
            flush_count <= flush_count + CNT_W'(1);
      end
   end

   assign pc_en       = en.pc;
   assign ifid_en     = en.ifid;
   assign idex_en     = en.idex;
   assign exmem_en    = en.exmem;
   assign memwb_en    = en.memwb;
   assign ifid_flush  = fl.ifid;
   assign idex_flush  = fl.idex;
   assign exmem_flush = fl.exmem;
   assign memwb_flush = fl.memwb;
   assign halted      = (state == HALT);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed cycles, each pushing its expected
// controls/counters to a scoreboard that is popped and compared mid-cycle.
module tb_pipeline_hazard_ctrl;

   localparam int ADDR_W = 5;
   localparam int CNT_W  = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] id_rs1_addr, id_rs2_addr, idex_addr_rd;
   logic              id_uses_rs1, id_uses_rs2, idex_mem_re;
   logic              exmem_branch_taken, exmem_mem_re, exmem_mem_we, dmem_ready;
   logic              pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic              ifid_flush, idex_flush, exmem_flush, memwb_flush;
   logic              halted;
   logic [CNT_W-1:0]  stall_cycles, flush_count;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string       tag;
      logic [4:0]  en;
      logic [3:0]  fl;
      logic        halt;
      int unsigned stall;
      int unsigned flc;
   } exp_t;

   exp_t sb[$];

   localparam logic [4:0] E_ALL = 5'b11111;
   localparam logic [4:0] E_NON = 5'b00000;
   localparam logic [4:0] E_FRZ = 5'b00001;
   localparam logic [4:0] E_LU  = 5'b00111;
   localparam logic [3:0] F_NON = 4'b0000;
   localparam logic [3:0] F_FRZ = 4'b0001;
   localparam logic [3:0] F_LU  = 4'b0100;
   localparam logic [3:0] F_BR  = 4'b1110;

   pipeline_hazard_ctrl #(
      .ADDR_W(ADDR_W), .MEM_TIMEOUT(4), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .idex_mem_re(idex_mem_re), .idex_addr_rd(idex_addr_rd),
      .exmem_branch_taken(exmem_branch_taken),
      .exmem_mem_re(exmem_mem_re), .exmem_mem_we(exmem_mem_we),
      .dmem_ready(dmem_ready),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
      .exmem_en(exmem_en), .memwb_en(memwb_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
      .halted(halted), .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Start a new cycle: wait for the falling edge and return inputs to idle
   task automatic nx(input logic rst = 1'b0);
      @(negedge clk);
      reset              = rst;
      id_rs1_addr        = '0;
      id_rs2_addr        = '0;
      id_uses_rs1        = 1'b0;
      id_uses_rs2        = 1'b0;
      idex_mem_re        = 1'b0;
      idex_addr_rd       = '0;
      exmem_branch_taken = 1'b0;
      exmem_mem_re       = 1'b0;
      exmem_mem_we       = 1'b0;
      dmem_ready         = 1'b1;
   endtask

   task automatic expect_cyc(input string tag, input logic [4:0] en, input logic [3:0] fl,
                             input logic halt, input int unsigned stall, input int unsigned flc);
      exp_t e;
      e.tag = tag; e.en = en; e.fl = fl; e.halt = halt; e.stall = stall; e.flc = flc;
      sb.push_back(e);
      #2;
      e = sb.pop_front();
      check({e.tag, ".en"},    64'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 64'(e.en));
      check({e.tag, ".flush"}, 64'({ifid_flush, idex_flush, exmem_flush, memwb_flush}), 64'(e.fl));
      check({e.tag, ".halt"},  64'(halted), 64'(e.halt));
      check({e.tag, ".stall"}, 64'(stall_cycles), 64'(e.stall));
      check({e.tag, ".flcnt"}, 64'(flush_count), 64'(e.flc));
   endtask

   task automatic set_lu(input logic [ADDR_W-1:0] rd, input logic [ADDR_W-1:0] rs1,
                         input logic u1, input logic [ADDR_W-1:0] rs2, input logic u2);
      idex_mem_re  = 1'b1;
      idex_addr_rd = rd;
      id_rs1_addr  = rs1;
      id_uses_rs1  = u1;
      id_rs2_addr  = rs2;
      id_uses_rs2  = u2;
   endtask

   initial begin
      reset = 1'b1;
      nx(1'b1);
      expect_cyc("reset", E_NON, F_NON, 1'b0, 0, 0);
      nx(1'b1); set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      expect_cyc("reset_lu", E_NON, F_NON, 1'b0, 0, 0);

      nx(); expect_cyc("idle0", E_ALL, F_NON, 1'b0, 0, 0);

      // Load-use hazards
      nx(); set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      expect_cyc("lu_rs1", E_LU, F_LU, 1'b0, 0, 0);
      nx(); expect_cyc("lu_after", E_ALL, F_NON, 1'b0, 1, 0);
      nx(); set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
      expect_cyc("lu_x0", E_ALL, F_NON, 1'b0, 1, 0);
      nx(); set_lu(5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
      expect_cyc("lu_rs2", E_LU, F_LU, 1'b0, 1, 0);
      nx(); set_lu(5'd7, 5'd7, 1'b0, 5'd7, 1'b0);
      expect_cyc("lu_unused", E_ALL, F_NON, 1'b0, 2, 0);
      nx(); set_lu(5'd9, 5'd9, 1'b1, 5'd0, 1'b0); idex_mem_re = 1'b0;
      expect_cyc("lu_noload", E_ALL, F_NON, 1'b0, 2, 0);

      // Branch beats load-use
      nx(); set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); exmem_branch_taken = 1'b1;
      expect_cyc("br_lu", E_ALL, F_BR, 1'b0, 2, 0);
      nx(); expect_cyc("br_after", E_ALL, F_NON, 1'b0, 2, 1);

      // Memory wait: three busy cycles then release
      for (int i = 0; i < 3; i++) begin
         nx(); exmem_mem_re = 1'b1; dmem_ready = 1'b0;
         expect_cyc($sformatf("mw_frz%0d", i), E_FRZ, F_FRZ, 1'b0, 2 + i, 1);
      end
      nx(); exmem_mem_re = 1'b1;
      expect_cyc("mw_rel", E_ALL, F_NON, 1'b0, 5, 1);
      nx(); expect_cyc("mw_run", E_ALL, F_NON, 1'b0, 5, 1);

      // Release cycle still applies load-use, then branch on a later release
      nx(); exmem_mem_re = 1'b1; dmem_ready = 1'b0;
      expect_cyc("mw2_frz", E_FRZ, F_FRZ, 1'b0, 5, 1);
      nx(); exmem_mem_re = 1'b1; set_lu(5'd4, 5'd0, 1'b0, 5'd4, 1'b1);
      expect_cyc("mw2_rel_lu", E_LU, F_LU, 1'b0, 6, 1);
      nx(); exmem_mem_we = 1'b1; dmem_ready = 1'b0;
      expect_cyc("mw3_frz", E_FRZ, F_FRZ, 1'b0, 7, 1);
      nx(); exmem_mem_we = 1'b1; exmem_branch_taken = 1'b1;
      expect_cyc("mw3_rel_br", E_ALL, F_BR, 1'b0, 8, 1);

      // Zero-wait store
      nx(); exmem_mem_we = 1'b1;
      expect_cyc("zw_store", E_ALL, F_NON, 1'b0, 8, 2);
      nx(); expect_cyc("zw_after", E_ALL, F_NON, 1'b0, 8, 2);

      // Reset during the second wait cycle
      nx(); exmem_mem_re = 1'b1; dmem_ready = 1'b0;
      expect_cyc("rw_frz", E_FRZ, F_FRZ, 1'b0, 8, 2);
      nx(1'b1); exmem_mem_re = 1'b1; dmem_ready = 1'b0;
      expect_cyc("rw_reset", E_NON, F_NON, 1'b0, 9, 2);
      nx(); expect_cyc("rw_run", E_ALL, F_NON, 1'b0, 0, 0);

      // Timeout into HALT after four frozen cycles
      for (int i = 0; i < 4; i++) begin
         nx(); exmem_mem_we = 1'b1; dmem_ready = 1'b0;
         expect_cyc($sformatf("to_frz%0d", i), E_FRZ, F_FRZ, 1'b0, i, 0);
      end
      nx(); exmem_mem_we = 1'b1; dmem_ready = 1'b0;
      expect_cyc("halt0", E_NON, F_NON, 1'b1, 4, 0);
      nx(); exmem_branch_taken = 1'b1; set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      expect_cyc("halt_br", E_NON, F_NON, 1'b1, 4, 0);
      nx(); exmem_mem_re = 1'b1;
      expect_cyc("halt_rdy", E_NON, F_NON, 1'b1, 4, 0);
      nx(1'b1); expect_cyc("halt_reset", E_NON, F_NON, 1'b1, 4, 0);
      nx(); expect_cyc("post_halt", E_ALL, F_NON, 1'b0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
